// File: rtl/memory_bus_interface_if.sv
// Memory-side bus of the Sayeh memory bus interface: registered address/data/strobes
// out to memory, read data and ready acknowledge back from memory.
interface memory_bus_interface_if;
  logic [15:0] MemAddr;
  logic [15:0] MemWdata;
  logic        MemRd;
  logic        MemWr;
  logic [15:0] MemRdata;
  logic        MemReady;

  modport master (
    output MemAddr,
    output MemWdata,
    output MemRd,
    output MemWr,
    input  MemRdata,
    input  MemReady
  );

  modport slave (
    input  MemAddr,
    input  MemWdata,
    input  MemRd,
    input  MemWr,
    output MemRdata,
    output MemReady
  );
endinterface

// File: rtl/memory_bus_interface.sv
// Single-transfer read/write sequencer between the Sayeh datapath and external memory,
// with a ready handshake, bounded wait and a one-cycle done/error pulse to the controller.
module memory_bus_interface #(
  parameter int unsigned TIMEOUT  = 15,
  parameter logic [15:0] ERR_DATA = 16'hFFFF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ReadMem,
  input  logic        WriteMem,
  input  logic [15:0] Addressbus,
  input  logic [15:0] Databus_out,
  output logic [15:0] Databus_in,
  output logic        MemDone,
  output logic        MemError,
  output logic        Busy,
  memory_bus_interface_if.master mem
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] RD_WAIT = 2'd1;
  localparam logic [1:0] WR_WAIT = 2'd2;
  localparam logic [1:0] DONE    = 2'd3;

  localparam logic       TO_EN   = (TIMEOUT != 0);
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  logic [1:0] state;
  logic [7:0] wait_cnt;
  logic       timed_out;

  // Timeout only fires when memory has not acknowledged in this same cycle.
  always_comb begin
    timed_out = TO_EN && (wait_cnt == TO_LAST);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      wait_cnt     <= '0;
      Databus_in   <= '0;
      MemDone      <= 1'b0;
      MemError     <= 1'b0;
      Busy         <= 1'b0;
      mem.MemAddr  <= '0;
      mem.MemWdata <= '0;
      mem.MemRd    <= 1'b0;
      mem.MemWr    <= 1'b0;
    end else begin
      MemDone  <= 1'b0;
      MemError <= 1'b0;
      case (state)
        IDLE: begin
          // Write has priority; a simultaneous read is silently dropped.
          if (WriteMem) begin
            mem.MemAddr  <= Addressbus;
            mem.MemWdata <= Databus_out;
            mem.MemWr    <= 1'b1;
            Busy         <= 1'b1;
            wait_cnt     <= '0;
            state        <= WR_WAIT;
          end else if (ReadMem) begin
            mem.MemAddr  <= Addressbus;
            mem.MemRd    <= 1'b1;
            Busy         <= 1'b1;
            wait_cnt     <= '0;
            state        <= RD_WAIT;
          end
        end

        RD_WAIT, WR_WAIT: begin
          if (mem.MemReady) begin
            if (state == RD_WAIT) begin
              Databus_in <= mem.MemRdata;
            end
            mem.MemRd <= 1'b0;
            mem.MemWr <= 1'b0;
            MemDone   <= 1'b1;
            state     <= DONE;
          end else if (timed_out) begin
            if (state == RD_WAIT) begin
              Databus_in <= ERR_DATA;
            end
            mem.MemRd <= 1'b0;
            mem.MemWr <= 1'b0;
            MemDone   <= 1'b1;
            MemError  <= 1'b1;
            state     <= DONE;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end

        DONE: begin
          Busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          mem.MemRd <= 1'b0;
          mem.MemWr <= 1'b0;
          Busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

  a_err_with_done: assert property (@(posedge clk) disable iff (!reset_n)
    MemError |-> MemDone);
  a_one_strobe: assert property (@(posedge clk) disable iff (!reset_n)
    !(mem.MemRd && mem.MemWr));

endmodule
